// File: rtl/binop_pair_sequencer.sv
// binop_pair_sequencer
//   Feeds a combinational BinOp stage and catches its result. It takes a byte
//   stream, pairs consecutive bytes into operands A (first) and B (second), and
//   holds them while BinOp settles. It then registers XOUT and presents it on a
//   valid/ready output. Only one operation is in flight at a time.
//
// Parameters
//   WIDTH   operand/result width (must match BinOp)
//   SETTLE  cycles A/B are held before XOUT is sampled, 1..15
//   CNT_W   width of the completed-operation counter
//
// Ports
//   CLK, RST                       clock (rising edge), synchronous active-high reset
//   IN_DATA/IN_VALID/IN_READY      operand byte stream
//   A, B                           registered operands to BinOp
//   XOUT                           BinOp result
//   OUT_DATA/OUT_VALID/OUT_READY   registered result stream
//   DIV_ZERO                       result came from B==0 (guard build only, else 0)
//   COUNT                          completed operations, wraps
//
// Build option
//   BINOP_DIV_ZERO_GUARD_EN  when defined, a B==0 operation yields OUT_DATA=0
//                            with DIV_ZERO=1 instead of the raw XOUT.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_GET_A   | waiting for the first byte (operand A)
// ST_GET_B   | waiting for the second byte (operand B)
// ST_SETTLE  | A/B held steady, counting down before XOUT is sampled
// ST_PRESENT | result on OUT_DATA, waiting for the consumer to take it

module binop_pair_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] XOUT,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             DIV_ZERO,
  output logic [CNT_W-1:0] COUNT
);

  typedef enum logic [1:0] {ST_GET_A, ST_GET_B, ST_SETTLE, ST_PRESENT} state_t;

  // Loaded on the B-accept edge; capture happens on the edge that sees zero,
  // so OUT_VALID rises exactly SETTLE edges after B is accepted.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             div_zero_q, div_zero_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_xfer;
  logic             out_xfer;

  assign IN_READY = (state_q == ST_GET_A) || (state_q == ST_GET_B);
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = out_valid_q && OUT_READY;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    div_zero_d   = div_zero_q;
    settle_cnt_d = settle_cnt_q;
    count_d      = count_q;

    case (state_q)
      ST_GET_A: begin
        if (in_xfer) begin
          a_d     = IN_DATA;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (in_xfer) begin
          b_d          = IN_DATA;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end else begin
`ifdef BINOP_DIV_ZERO_GUARD_EN
          if (b_q == '0) begin
            out_data_d = '0;
            div_zero_d = 1'b1;
          end else begin
            out_data_d = XOUT;
            div_zero_d = 1'b0;
          end
`else
          out_data_d = XOUT;
          div_zero_d = 1'b0;
`endif
          out_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          div_zero_d  = 1'b0;
          count_d     = count_q + CNT_W'(1);
          state_d     = ST_GET_A;
        end
      end
      default: state_d = ST_GET_A;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_GET_A;
      a_q          <= '0;
      b_q          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      div_zero_q   <= 1'b0;
      settle_cnt_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      div_zero_q   <= div_zero_d;
      settle_cnt_q <= settle_cnt_d;
      count_q      <= count_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign DIV_ZERO  = div_zero_q;
  assign COUNT     = count_q;

endmodule

// File: tb/tb_binop_pair_sequencer.sv
// Directed bench for binop_pair_sequencer. Instance u_s1 runs SETTLE=1 with
// a 16-bit counter; u_s3 runs SETTLE=3 with a 4-bit counter so wrap is
// reachable. XOUT is stubbed, or taken from a divide model of BinOp in the
// random-pair phase.

module tb_binop_pair_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        rst_1, in_valid_1, in_ready_1, out_valid_1, out_ready_1, div_zero_1;
  logic [7:0]  in_data_1, a_1, b_1, xout_1, out_data_1;
  logic [15:0] count_1;

  // SETTLE=3, CNT_W=4 instance
  logic        rst, in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [7:0]  in_data, a_o, b_o, xout, xout_stub, out_data;
  logic [3:0]  count;
  logic        use_binop;

  // BinOp model: integer divide, B is never zero while it is in use
  assign xout = use_binop ? ((b_o != 8'd0) ? (a_o / b_o) : 8'd0) : xout_stub;

  binop_pair_sequencer #(.WIDTH(8), .SETTLE(1), .CNT_W(16)) u_s1 (
    .CLK(clk), .RST(rst_1), .IN_DATA(in_data_1), .IN_VALID(in_valid_1),
    .IN_READY(in_ready_1), .A(a_1), .B(b_1), .XOUT(xout_1),
    .OUT_DATA(out_data_1), .OUT_VALID(out_valid_1), .OUT_READY(out_ready_1),
    .DIV_ZERO(div_zero_1), .COUNT(count_1)
  );

  binop_pair_sequencer #(.WIDTH(8), .SETTLE(3), .CNT_W(4)) u_s3 (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .A(a_o), .B(b_o), .XOUT(xout),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .DIV_ZERO(div_zero), .COUNT(count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte to u_s3 once it is ready, then drop IN_VALID.
  task automatic send_byte(input logic [7:0] d);
    int i;
    for (i = 0; i < 50 && !in_ready; i++) tick();
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  logic [7:0] exp_data;
  logic       exp_dz;
  logic [7:0] pa, pb;
  logic       seen, done;

  initial begin
    rst_1 = 1'b1; in_valid_1 = 1'b0; out_ready_1 = 1'b0; in_data_1 = 8'h00; xout_1 = 8'h00;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00; xout_stub = 8'h00;
    use_binop = 1'b0;
    tick(); tick(); tick();

    // reset values
    chk("rst_a", {24'd0, a_o}, 32'h0);
    chk("rst_b", {24'd0, b_o}, 32'h0);
    chk("rst_out_data", {24'd0, out_data}, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    rst = 1'b0; rst_1 = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: SETTLE=1, XOUT=A5, 05 then 03
    xout_1 = 8'hA5; out_ready_1 = 1'b1;
    in_data_1 = 8'h05; in_valid_1 = 1'b1;
    tick();
    chk("t1_a", {24'd0, a_1}, 32'h05);
    chk("t1_ready_b", {31'd0, in_ready_1}, 32'd1);
    in_data_1 = 8'h03;
    tick();
    in_valid_1 = 1'b0;
    chk("t1_b", {24'd0, b_1}, 32'h03);
    chk("t1_settle_valid", {31'd0, out_valid_1}, 32'd0);
    chk("t1_settle_ready", {31'd0, in_ready_1}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, out_valid_1}, 32'd1);
    chk("t1_data", {24'd0, out_data_1}, 32'hA5);
    chk("t1_count0", {16'd0, count_1}, 32'd0);
    tick();
    chk("t1_xfer_valid", {31'd0, out_valid_1}, 32'd0);
    chk("t1_count1", {16'd0, count_1}, 32'd1);
    chk("t1_a_hold", {24'd0, a_1}, 32'h05);
    chk("t1_b_hold", {24'd0, b_1}, 32'h03);

    // 2: SETTLE=3, XOUT changes 11->22 two cycles after B accept
    xout_stub = 8'h11; out_ready = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t2_ready_e0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t2_valid_e1", {31'd0, out_valid}, 32'd0);
    chk("t2_ready_e1", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t2_valid_e2", {31'd0, out_valid}, 32'd0);
    xout_stub = 8'h22;
    tick();
    chk("t2_valid_e3", {31'd0, out_valid}, 32'd1);
    chk("t2_data", {24'd0, out_data}, 32'h22);
    chk("t2_ready_present", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t2_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_count", {28'd0, count}, 32'd1);

    // 3: consumer stalls 10 cycles while new data is offered
    out_ready = 1'b0; xout_stub = 8'h77;
    send_byte(8'h30);
    send_byte(8'h06);
    wait_valid("t3_valid_rise");
    in_data = 8'hEE; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_data_hold", {24'd0, out_data}, 32'h77);
      chk("t3_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("t3_ready_low", {31'd0, in_ready}, 32'd0);
      chk("t3_a_hold", {24'd0, a_o}, 32'h30);
      chk("t3_b_hold", {24'd0, b_o}, 32'h06);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t3_xfer_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_count", {28'd0, count}, 32'd2);
    chk("t3_a_not_taken", {24'd0, a_o}, 32'h30);

    // 4: divide by zero
    xout_stub = 8'h5A;
`ifdef BINOP_DIV_ZERO_GUARD_EN
    exp_data = 8'h00; exp_dz = 1'b1;
`else
    exp_data = 8'h5A; exp_dz = 1'b0;
`endif
    send_byte(8'h07);
    send_byte(8'h00);
    wait_valid("t4_valid");
    chk("t4_data", {24'd0, out_data}, {24'd0, exp_data});
    chk("t4_div_zero", {31'd0, div_zero}, {31'd0, exp_dz});
    tick();
    chk("t4_count", {28'd0, count}, 32'd3);
    chk("t4_dz_clear", {31'd0, div_zero}, 32'd0);

    // 5: reset one cycle after accepting A=09
    xout_stub = 8'h3C;
    send_byte(8'h09);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_a_cleared", {24'd0, a_o}, 32'h0);
    chk("t5_count_cleared", {28'd0, count}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h04);
    send_byte(8'h02);
    wait_valid("t5_valid");
    chk("t5_a", {24'd0, a_o}, 32'h04);
    chk("t5_b", {24'd0, b_o}, 32'h02);
    chk("t5_data", {24'd0, out_data}, 32'h3C);
    tick();
    chk("t5_count", {28'd0, count}, 32'd1);

    // 5b: reset while a result is pending drops it
    out_ready = 1'b0;
    send_byte(8'h10);
    send_byte(8'h20);
    wait_valid("t5b_valid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5b_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t5b_data_clear", {24'd0, out_data}, 32'h0);
    chk("t5b_count_clear", {28'd0, count}, 32'd0);

    // 6: 17 random pairs through the divide model, random back-pressure
    use_binop = 1'b1;
    for (int k = 0; k < 17; k++) begin
      pa = 8'($urandom_range(0, 255));
      pb = 8'($urandom_range(1, 255));
      send_byte(pa);
      send_byte(pb);
      seen = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && !seen) begin
          chk("t6_data", {24'd0, out_data}, {24'd0, pa / pb});
          seen = 1'b1;
        end
        if (out_valid && out_ready) done = 1'b1;
        tick();
      end
      chk("t6_xfer_done", {31'd0, done}, 32'd1);
    end
    out_ready = 1'b0;
    chk("t6_count_wrap", {28'd0, count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
